uart_tx_engine: RTL and testbench

Serial transmit stage directly downstream of the UART AXI-lite register controller. It consumes the registered configuration and data outputs: tx_enable, tx_data, data_bit_num, parity, stop_bit_num and baud_tick_val. It produces the serial line plus the three completion status inputs that the controller mirrors into its status register. One frame is sent per tx_enable assertion, LSB first.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_engine.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: FSM encoding, config bit meanings, line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } tx_state_t;

    localparam logic DATA_BITS_8 = 1'b0;
    localparam logic DATA_BITS_7 = 1'b1;
    localparam logic STOP_BITS_1 = 1'b0;
    localparam logic STOP_BITS_2 = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..N-1 and flags the last cycle of each bit (N of 0 or 1 acts as 1).
module uart_baud_gen #(
    parameter int BAUD_VALUE_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        a_rst_n_i,
    input  logic                        clear_i,
    input  logic [BAUD_VALUE_WIDTH-1:0] baud_val_i,
    output logic                        tick_o
);

    logic [BAUD_VALUE_WIDTH-1:0] cnt_r;
    logic [BAUD_VALUE_WIDTH-1:0] last_s;

    // Terminal count decode; clear keeps the timer parked so the first bit is a full period.
    always_comb begin
        last_s = '0;
        tick_o = 1'b0;
        if (baud_val_i > BAUD_VALUE_WIDTH'(1)) begin
            last_s = baud_val_i - BAUD_VALUE_WIDTH'(1);
        end else begin
            last_s = '0;
        end
        if (clear_i) begin
            tick_o = 1'b0;
        end else begin
            tick_o = (cnt_r == last_s);
        end
    end

    // Cycle counter within the current bit.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            cnt_r <= '0;
        end else if (clear_i || tick_o) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + BAUD_VALUE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART serial transmitter: one LSB-first frame per tx_enable request, configuration shadowed at start.
// Optional even parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int BAUD_VALUE_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        a_rst_n_i,
    input  logic                        tx_enable_i,
    input  logic [DATA_WIDTH-1:0]       tx_data_i,
    input  logic                        data_bit_num_i,
    input  logic                        parity_i,
    input  logic                        stop_bit_num_i,
    input  logic [BAUD_VALUE_WIDTH-1:0] baud_tick_val_i,
    output logic                        tx_o,
    output logic                        start_complete_o,
    output logic                        data_complete_o,
    output logic                        tx_complete_o
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    tx_state_t                   state_r;
    logic [DATA_WIDTH-1:0]       data_r;
    logic                        data7_r;
    logic                        stop2_r;
    logic [BAUD_VALUE_WIDTH-1:0] baud_r;
    logic [IDX_W-1:0]            bit_idx_r;
    logic                        stop_cnt_r;
    logic                        tx_r;
    logic                        start_done_r;
    logic                        data_done_r;
    logic                        tx_done_r;
    logic                        tick_s;
    logic                        baud_clear_s;
    logic [IDX_W-1:0]            last_idx_s;

`ifdef UART_TX_PARITY_EN
    logic                        parity_en_r;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d, input logic short_frame);
        logic [DATA_WIDTH-1:0] m;
        m = d;
        if (short_frame) begin
            m[DATA_WIDTH-1] = 1'b0;
        end
        return ^m;
    endfunction
`else
    logic                        unused_parity_s;
    assign unused_parity_s = parity_i;
`endif

    assign baud_clear_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign last_idx_s   = (data7_r == DATA_BITS_7) ? IDX_W'(DATA_WIDTH - 2) : IDX_W'(DATA_WIDTH - 1);

    uart_baud_gen #(
        .BAUD_VALUE_WIDTH(BAUD_VALUE_WIDTH)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .a_rst_n_i  (a_rst_n_i),
        .clear_i    (baud_clear_s),
        .baud_val_i (baud_r),
        .tick_o     (tick_s)
    );

    // Frame sequencer; tx_r is loaded with the level of the state being entered.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_r      <= ST_IDLE;
            data_r       <= '0;
            data7_r      <= 1'b0;
            stop2_r      <= 1'b0;
            baud_r       <= '0;
            bit_idx_r    <= '0;
            stop_cnt_r   <= 1'b0;
            tx_r         <= IDLE_LEVEL;
            start_done_r <= 1'b0;
            data_done_r  <= 1'b0;
            tx_done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tx_enable_i) begin
                        data_r       <= tx_data_i;
                        data7_r      <= data_bit_num_i;
                        stop2_r      <= stop_bit_num_i;
                        baud_r       <= baud_tick_val_i;
`ifdef UART_TX_PARITY_EN
                        parity_en_r  <= parity_i;
`endif
                        bit_idx_r    <= '0;
                        stop_cnt_r   <= 1'b0;
                        start_done_r <= 1'b0;
                        data_done_r  <= 1'b0;
                        tx_done_r    <= 1'b0;
                        tx_r         <= 1'b0;
                        state_r      <= ST_START;
                    end else begin
                        tx_r <= IDLE_LEVEL;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        start_done_r <= 1'b1;
                        tx_r         <= data_r[0];
                        state_r      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == last_idx_s) begin
`ifdef UART_TX_PARITY_EN
                            if (parity_en_r) begin
                                tx_r    <= even_parity(data_r, data7_r);
                                state_r <= ST_PARITY;
                            end else begin
                                data_done_r <= 1'b1;
                                tx_r        <= IDLE_LEVEL;
                                state_r     <= ST_STOP;
                            end
`else
                            data_done_r <= 1'b1;
                            tx_r        <= IDLE_LEVEL;
                            state_r     <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                            tx_r      <= data_r[bit_idx_r + IDX_W'(1)];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        data_done_r <= 1'b1;
                        tx_r        <= IDLE_LEVEL;
                        state_r     <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        if ((stop2_r == STOP_BITS_2) && !stop_cnt_r) begin
                            stop_cnt_r <= 1'b1;
                        end else begin
                            tx_done_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    tx_r <= IDLE_LEVEL;
                    // Wait for the controller to drop the request so one request never sends twice.
                    if (!tx_enable_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_r    <= IDLE_LEVEL;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_o             = tx_r;
    assign start_complete_o = start_done_r;
    assign data_complete_o  = data_done_r;
    assign tx_complete_o    = tx_done_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed and randomized frames against a bit-list reference model.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        a_rst_n_i;
    logic        tx_enable_i;
    logic [7:0]  tx_data_i;
    logic        data_bit_num_i;
    logic        parity_i;
    logic        stop_bit_num_i;
    logic [15:0] baud_tick_val_i;
    logic        tx_o;
    logic        start_complete_o;
    logic        data_complete_o;
    logic        tx_complete_o;

    int errors = 0;
    int checks = 0;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_engine #(
        .DATA_WIDTH       (8),
        .BAUD_VALUE_WIDTH (16)
    ) dut (
        .clk_i            (clk),
        .a_rst_n_i        (a_rst_n_i),
        .tx_enable_i      (tx_enable_i),
        .tx_data_i        (tx_data_i),
        .data_bit_num_i   (data_bit_num_i),
        .parity_i         (parity_i),
        .stop_bit_num_i   (stop_bit_num_i),
        .baud_tick_val_i  (baud_tick_val_i),
        .tx_o             (tx_o),
        .start_complete_o (start_complete_o),
        .data_complete_o  (data_complete_o),
        .tx_complete_o    (tx_complete_o)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {tx,start,data,done}=%b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] obs();
        return {tx_o, start_complete_o, data_complete_o, tx_complete_o};
    endfunction

    // Called at a falling edge. Expected line is built as a list of levels, one per clock.
    task automatic send_frame(input logic [7:0] data, input logic d7, input logic par, input logic s2,
                              input logic [15:0] baud, input int hold, input bit perturb, input bit drop_mid);
        int   n;
        int   nb;
        int   p;
        int   total;
        int   tdc;
        logic pbit;
        logic [3:0] e;
        logic exp_q[$];
        n  = (baud < 16'd2) ? 1 : int'(baud);
        nb = d7 ? 7 : 8;
        p  = (PAR_BUILD && par) ? 1 : 0;
        pbit = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < nb; b++) begin
            pbit = pbit ^ data[b];
            for (int i = 0; i < n; i++) exp_q.push_back(data[b]);
        end
        if (p == 1) begin
            for (int i = 0; i < n; i++) exp_q.push_back(pbit);
        end
        for (int i = 0; i < n * (s2 ? 2 : 1); i++) exp_q.push_back(1'b1);
        total = exp_q.size();
        tdc   = n * (1 + nb + p);

        tx_data_i       = data;
        data_bit_num_i  = d7;
        parity_i        = par;
        stop_bit_num_i  = s2;
        baud_tick_val_i = baud;
        tx_enable_i     = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            e = {(k <= total) ? exp_q[k-1] : 1'b1, (k - 1) >= n, (k - 1) >= tdc, (k - 1) >= total};
            check_eq("frame", obs(), e);
            if (perturb && k == 2) begin
                tx_data_i       = 8'($urandom);
                baud_tick_val_i = 16'($urandom_range(0, 6));
                data_bit_num_i  = 1'($urandom);
                stop_bit_num_i  = 1'($urandom);
                parity_i        = 1'($urandom);
                if (drop_mid) tx_enable_i = 1'b0;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("done_hold", obs(), 4'b1111);
        end
        tx_enable_i = 1'b0;
        @(negedge clk);
        check_eq("idle_flags", obs(), 4'b1111);
    endtask

    initial begin
        bit dm;
        a_rst_n_i       = 1'b0;
        tx_enable_i     = 1'b0;
        tx_data_i       = 8'h00;
        data_bit_num_i  = 1'b0;
        parity_i        = 1'b0;
        stop_bit_num_i  = 1'b0;
        baud_tick_val_i = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("reset", obs(), 4'b1000);
        a_rst_n_i = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", obs(), 4'b1000);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, 0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 16'd2, 0, 1'b0, 1'b0);
        send_frame(8'h03, 1'b0, 1'b1, 1'b0, 16'd1, 0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 16'd1, 0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16'd3, 5, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 16'd3, 0, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 16'd0, 0, 1'b1, 1'b1);

        // Abort a frame during its data bits with an asynchronous reset.
        tx_data_i       = 8'h00;
        data_bit_num_i  = 1'b0;
        parity_i        = 1'b0;
        stop_bit_num_i  = 1'b0;
        baud_tick_val_i = 16'd3;
        tx_enable_i     = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        check_eq("pre_reset_data", obs(), 4'b0100);
        #1 a_rst_n_i = 1'b0;
        #1 check_eq("async_reset", obs(), 4'b1000);
        @(negedge clk);
        a_rst_n_i = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16'd3, 0, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            dm = 1'($urandom);
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       16'($urandom_range(0, 5)), dm ? 0 : int'($urandom_range(0, 3)),
                       1'($urandom), dm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
